demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1ton

Overview:
- Registered, parametrised 1-to-N demultiplexer for valid/ready streams; generalises the combinational 1:2 demux to N channels with configurable data width.
- One input stream is routed to one of N output channels, chosen either by an explicit select or by an internal round-robin pointer.
- One register stage with full-throughput backpressure handling.
- Sits between a single producer and N downstream consumers in datapath fabric.

Parameters:
- WIDTH, 8, data width per channel.
- N, 4, number of output channels; N >= 2.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_W  destination channel; used when rr_mode=0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- rr_mode  input  1  1 = round-robin distribution, in_sel ignored.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  N  per-channel valid; at most one bit set.
- out_ready  input  N  per-channel ready from consumers.
- rr_ptr  output  SEL_W  next round-robin destination.
- err_cnt  output  CNT_W  count of dropped beats (in_sel >= N).

Behaviour:
- **Reset (async, immediate):**
  - hold register empty; out_valid=0; out_data=0; rr_ptr=0; err_cnt=0.
  - Reset mid-transfer discards the held beat with no output.
- **Storage:** one holding register (hold_v, hold_dest, hold_data).
- **Outputs:**
  - out_valid[k] = hold_v && hold_dest==k.
  - Lane hold_dest carries hold_data; every other lane is driven 0.
  - No lane carries data when hold_v=0.
- **Handshakes:**
  - Input accepted when in_valid && in_ready; in_ready = !hold_v || out_ready[hold_dest] (combinational).
  - Output transfer on channel k when out_valid[k] && out_ready[k].
  - Output transfer and new acceptance in the same cycle: the register reloads, giving back-to-back throughput of 1 beat/cycle.
  - Output transfer with no acceptance: hold_v clears.
- **Latency:** accepted beat appears on its output the next cycle.
- **Stall:** while out_ready[hold_dest]=0, hold_data, hold_dest and out_valid are stable; no input is accepted.
- **Destination on acceptance:**
  - rr_mode=1: dest = rr_ptr; rr_ptr advances by 1 and wraps from N-1 to 0.
  - rr_mode=0: dest = in_sel; rr_ptr holds.
- **rr_mode changes** are sampled per acceptance. No pointer reset on a mode change.
- **Invalid select** (rr_mode=0, in_sel >= N, only possible when N < 2**SEL_W):
  - beat is accepted (in_ready as normal) and dropped;
  - the hold register does not load; if it transferred this cycle, it empties;
  - err_cnt increments and saturates at 2**CNT_W-1 with no wrap.
- **Quiet cycles:** no state change while in_valid=0, except a pending output completing.
- **Data integrity:** out_ready on non-selected channels is ignored. Data is never duplicated to two channels and never lost while in_ready is honoured.

Test Plan:
1. **Directed routing:** N=4, WIDTH=8, rr_mode=0, all out_ready=1; send 0x11,0x22,0x33,0x44 with in_sel 0,1,2,3 on consecutive cycles.
   - Expect: out_valid 0001,0010,0100,1000 one cycle later, matching lanes; other lanes 0; in_ready stays 1.
2. **Backpressure:** hold 0xA5 to channel 2 with out_ready[2]=0 for 3 cycles while in_valid=1 with 0x5A.
   - Expect: in_ready=0 for 3 cycles; out_data lane 2 stable at 0xA5.
   - Raise out_ready[2]: 0xA5 transfers and 0x5A is accepted the same cycle.
3. **Round-robin wrap:** rr_mode=1; send 6 beats with in_sel=3 held throughout.
   - Expect destinations 0,1,2,3,0,1; rr_ptr ends at 2.
4. **Invalid select:** N=3, SEL_W=2, rr_mode=0; send in_sel=3 three times, then in_sel=1 with 0x7E.
   - Expect: no out_valid for the first three beats; err_cnt=3; 0x7E on lane 1.
   - CNT_W=2 variant: a 4th invalid beat leaves err_cnt=3.
5. **Reset mid-operation:** with a beat held (out_ready=0) and rr_ptr=2, assert rst between clock edges.
   - Expect: out_valid=0, out_data=0, rr_ptr=0, err_cnt=0 immediately, without waiting for a clock edge.
   - After release, the first beat routes normally.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N valid/ready stream demultiplexer with explicit or round-robin
// destination selection and a saturating count of beats dropped for bad selects.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rr_mode,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [SEL_W-1:0]   rr_ptr,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N-1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic               hold_v_r;
    logic [SEL_W-1:0]   hold_dest_r;
    logic [WIDTH-1:0]   hold_data_r;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [N-1:0]       out_valid_r;
    logic [N*WIDTH-1:0] out_data_r;

    logic               sel_ready_s;
    logic               xfer_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [SEL_W-1:0]   dest_s;
    logic               dest_ok_s;

    logic               hold_v_nxt_s;
    logic [SEL_W-1:0]   hold_dest_nxt_s;
    logic [WIDTH-1:0]   hold_data_nxt_s;
    logic [SEL_W-1:0]   rr_ptr_nxt_s;
    logic [CNT_W-1:0]   err_cnt_nxt_s;
    logic [N-1:0]       out_valid_nxt_s;
    logic [N*WIDTH-1:0] out_data_nxt_s;

    // Ready of the consumer currently addressed by the holding register; other lanes are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            sel_ready_s = sel_ready_s | (out_ready[k] & (hold_dest_r == SEL_W'(k)));
        end
    end

    assign xfer_s     = hold_v_r & sel_ready_s;
    assign in_ready_s = ~hold_v_r | sel_ready_s;
    assign accept_s   = in_valid & in_ready_s;
    assign dest_s     = rr_mode ? rr_ptr_r : in_sel;
    assign dest_ok_s  = ({1'b0, dest_s} < N_EXT);

    // Holding register next state: reload on a routable acceptance, otherwise drain on transfer.
    always_comb begin
        hold_v_nxt_s    = hold_v_r;
        hold_dest_nxt_s = hold_dest_r;
        hold_data_nxt_s = hold_data_r;
        if (accept_s && dest_ok_s) begin
            hold_v_nxt_s    = 1'b1;
            hold_dest_nxt_s = dest_s;
            hold_data_nxt_s = in_data;
        end else if (xfer_s) begin
            hold_v_nxt_s    = 1'b0;
        end else begin
            hold_v_nxt_s    = hold_v_r;
        end
    end

    // Round-robin pointer advances only on beats it actually routed; mode changes never reset it.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        if (accept_s && rr_mode) begin
            rr_ptr_nxt_s = (rr_ptr_r == LAST_CH) ? {SEL_W{1'b0}} : rr_ptr_r + SEL_W'(1);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Dropped-beat counter saturates instead of wrapping.
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        if (accept_s && !dest_ok_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_nxt_s = err_cnt_r + CNT_W'(1);
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // Lane decode of the next holding state so the outputs come straight from flops.
    always_comb begin
        out_valid_nxt_s = {N{1'b0}};
        out_data_nxt_s  = {(N*WIDTH){1'b0}};
        for (int k = 0; k < N; k++) begin
            if (hold_v_nxt_s && (hold_dest_nxt_s == SEL_W'(k))) begin
                out_valid_nxt_s[k]               = 1'b1;
                out_data_nxt_s[k*WIDTH +: WIDTH] = hold_data_nxt_s;
            end else begin
                out_valid_nxt_s[k]               = 1'b0;
                out_data_nxt_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
        end
    end

    // State and output registers; reset empties the stage and discards any held beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_r    <= 1'b0;
            hold_dest_r <= {SEL_W{1'b0}};
            hold_data_r <= {WIDTH{1'b0}};
            rr_ptr_r    <= {SEL_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            out_valid_r <= {N{1'b0}};
            out_data_r  <= {(N*WIDTH){1'b0}};
        end else begin
            hold_v_r    <= hold_v_nxt_s;
            hold_dest_r <= hold_dest_nxt_s;
            hold_data_r <= hold_data_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign rr_ptr    = rr_ptr_r;
    assign err_cnt   = err_cnt_r;

    demux_stream_1ton_chk #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (out_data_r)
    );

endmodule

// Protocol properties of the output side: one channel at most, and stalled beats hold still.
module demux_stream_1ton_chk #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [N-1:0]       out_valid,
    input logic [N-1:0]       out_ready,
    input logic [N*WIDTH-1:0] out_data
);

    a_onehot_valid: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        ((out_valid & ~out_ready) != {N{1'b0}}) |=> ($stable(out_valid) && $stable(out_data)));

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench: a vector table on a 4-channel instance, plus hand-written sequences
// for bad selects on a 3-channel/2-bit-counter instance and asynchronous reset.
module tb_demux_stream_1ton;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic        rr;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_ptr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  in_data  = 8'h00;
    logic [1:0]  in_sel   = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rr_mode  = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [1:0]  rr_ptr;
    logic [7:0]  err_cnt;

    logic [7:0]  in3_data  = 8'h00;
    logic [1:0]  in3_sel   = 2'd0;
    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [23:0] out3_data;
    logic [2:0]  out3_valid;
    logic [2:0]  out3_ready = 3'b111;
    logic [1:0]  rr3_ptr;
    logic [1:0]  err3_cnt;

    int total = 0;
    int bad   = 0;
    vec_t vec [0:17];

    always #5 clk = ~clk;

    demux_stream_1ton #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .rr_mode(rr_mode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rr_ptr(rr_ptr), .err_cnt(err_cnt)
    );

    demux_stream_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in3_data), .in_sel(in3_sel), .in_valid(in3_valid),
        .in_ready(in3_ready), .rr_mode(1'b0), .out_data(out3_data), .out_valid(out3_valid),
        .out_ready(out3_ready), .rr_ptr(rr3_ptr), .err_cnt(err3_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [7:0] d,
                                input logic r, input logic [3:0] o, input logic er,
                                input logic [3:0] eov, input logic [31:0] eod, input logic [1:0] ep);
        vec_t t;
        t.valid = v; t.sel = s; t.data = d; t.rr = r; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ptr = ep;
        return t;
    endfunction

    // Called at posedge+1: drive, check ready, clock, check registered outputs.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        in_valid = v.valid; in_sel = v.sel; in_data = v.data; rr_mode = v.rr; out_ready = v.ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        check({tag, ".out_data"}, out_data, v.exp_od);
        check({tag, ".rr_ptr"}, 32'(rr_ptr), 32'(v.exp_ptr));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic apply3(input logic [1:0] s, input logic [7:0] d, input logic [2:0] eov,
                          input logic [23:0] eod, input logic [1:0] eerr, input string tag);
        in3_valid = 1'b1; in3_sel = s; in3_data = d;
        #1;
        check({tag, ".in_ready"}, 32'(in3_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 32'(out3_valid), 32'(eov));
        check({tag, ".out_data"}, 32'(out3_data), 32'(eod));
        check({tag, ".err_cnt"}, 32'(err3_cnt), 32'(eerr));
    endtask

    initial begin
        // Directed routing
        vec[0]  = mk(1'b1, 2'd0, 8'h11, 1'b0, 4'hF, 1'b1, 4'b0001, 32'h0000_0011, 2'd0);
        vec[1]  = mk(1'b1, 2'd1, 8'h22, 1'b0, 4'hF, 1'b1, 4'b0010, 32'h0000_2200, 2'd0);
        vec[2]  = mk(1'b1, 2'd2, 8'h33, 1'b0, 4'hF, 1'b1, 4'b0100, 32'h0033_0000, 2'd0);
        vec[3]  = mk(1'b1, 2'd3, 8'h44, 1'b0, 4'hF, 1'b1, 4'b1000, 32'h4400_0000, 2'd0);
        // Backpressure on channel 2; other lanes' ready must not matter
        vec[4]  = mk(1'b1, 2'd2, 8'hA5, 1'b0, 4'hF, 1'b1, 4'b0100, 32'h00A5_0000, 2'd0);
        vec[5]  = mk(1'b1, 2'd0, 8'h5A, 1'b0, 4'b1011, 1'b0, 4'b0100, 32'h00A5_0000, 2'd0);
        vec[6]  = mk(1'b1, 2'd0, 8'h5A, 1'b0, 4'b1011, 1'b0, 4'b0100, 32'h00A5_0000, 2'd0);
        vec[7]  = mk(1'b1, 2'd0, 8'h5A, 1'b0, 4'b1011, 1'b0, 4'b0100, 32'h00A5_0000, 2'd0);
        vec[8]  = mk(1'b1, 2'd0, 8'h5A, 1'b0, 4'hF, 1'b1, 4'b0001, 32'h0000_005A, 2'd0);
        vec[9]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 2'd0);
        // Round-robin with in_sel held at 3
        vec[10] = mk(1'b1, 2'd3, 8'h01, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h0000_0001, 2'd1);
        vec[11] = mk(1'b1, 2'd3, 8'h02, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h0000_0200, 2'd2);
        vec[12] = mk(1'b1, 2'd3, 8'h03, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h0003_0000, 2'd3);
        vec[13] = mk(1'b1, 2'd3, 8'h04, 1'b1, 4'hF, 1'b1, 4'b1000, 32'h0400_0000, 2'd0);
        vec[14] = mk(1'b1, 2'd3, 8'h05, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h0000_0005, 2'd1);
        vec[15] = mk(1'b1, 2'd3, 8'h06, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h0000_0600, 2'd2);
        // Back to explicit select: pointer is kept
        vec[16] = mk(1'b1, 2'd3, 8'h77, 1'b0, 4'hF, 1'b1, 4'b1000, 32'h7700_0000, 2'd2);
        vec[17] = mk(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 2'd2);

        #12 rst = 1'b0;
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", out_data, 32'd0);
        check("reset.rr_ptr", 32'(rr_ptr), 32'd0);
        check("reset.err_cnt", 32'(err_cnt), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            apply(vec[i], i);
        end

        // Bad selects on the 3-channel instance; 2-bit counter saturates at 3
        apply3(2'd3, 8'hE1, 3'b000, 24'h000000, 2'd1, "inv1");
        apply3(2'd3, 8'hE2, 3'b000, 24'h000000, 2'd2, "inv2");
        apply3(2'd3, 8'hE3, 3'b000, 24'h000000, 2'd3, "inv3");
        apply3(2'd1, 8'h7E, 3'b010, 24'h007E00, 2'd3, "good");
        apply3(2'd3, 8'hE4, 3'b000, 24'h000000, 2'd3, "inv4_sat");
        in3_valid = 1'b0;

        // Hold a beat under backpressure with rr_ptr=2, then reset between edges
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h99; rr_mode = 1'b0; out_ready = 4'h0;
        @(posedge clk); #1;
        check("held.out_valid", 32'(out_valid), 32'b0010);
        check("held.rr_ptr", 32'(rr_ptr), 32'd2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst.out_valid", 32'(out_valid), 32'd0);
        check("async_rst.out_data", out_data, 32'd0);
        check("async_rst.rr_ptr", 32'(rr_ptr), 32'd0);
        check("async_rst.err_cnt", 32'(err_cnt), 32'd0);
        check("async_rst.err3_cnt", 32'(err3_cnt), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        apply(mk(1'b1, 2'd2, 8'hC3, 1'b0, 4'hF, 1'b1, 4'b0100, 32'h00C3_0000, 2'd0), 100);
        apply(mk(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 2'd0), 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
